// File: rtl/wb_mem_master.sv
// CPU-side Wishbone classic master for the DDR2 slave: one-entry posted-write
// buffer, calibration gating, forced idle gap between cycles and a per-cycle timeout.
module wb_mem_master #(
    parameter int unsigned TIMEOUT        = 1024,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        calib_done_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [26:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam int unsigned CNT_MAX = (TIMEOUT > RECOVER_CYCLES) ? TIMEOUT : RECOVER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned ADR_W   = 27;
    localparam int unsigned DAT_W   = 32;
    localparam int unsigned SEL_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RECOVER
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wbuf_valid_q, wbuf_valid_d;
    logic [ADR_W-1:0]   wbuf_adr_q, wbuf_adr_d;
    logic [DAT_W-1:0]   wbuf_dat_q, wbuf_dat_d;
    logic [SEL_W-1:0]   wbuf_sel_q, wbuf_sel_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               ready_q, ready_d;
    logic [DAT_W-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               cur_req;
    logic               store_act;
    logic               load_act;
    logic               bus_to;
    logic               wr_done;
    logic               launch;
    logic [ADR_W-1:0]   cpu_adr_w;
    logic               unused_addr_bits;

    // The CPU holds its request until the ready pulse, so the ready cycle itself
    // is the only one where a stale request is visible.
    assign cur_req   = cpu_req_i && !ready_q;
    assign store_act = cur_req && cpu_we_i;
    assign load_act  = cur_req && !cpu_we_i;
    assign bus_to    = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign wr_done   = (state_q == ST_BUS_WR) && (wb_ack_i || bus_to);
    assign cpu_adr_w = {cpu_addr_i[26:2], 2'b00};

    assign unused_addr_bits = ^{cpu_addr_i[31:27], cpu_addr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wbuf_valid_q <= 1'b0;
            wbuf_adr_q   <= '0;
            wbuf_dat_q   <= '0;
            wbuf_sel_q   <= '0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_adr_q   <= wbuf_adr_d;
            wbuf_dat_q   <= wbuf_dat_d;
            wbuf_sel_q   <= wbuf_sel_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wbuf_valid_d = wbuf_valid_q;
        wbuf_adr_d   = wbuf_adr_q;
        wbuf_dat_d   = wbuf_dat_q;
        wbuf_sel_d   = wbuf_sel_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        ready_d      = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        launch       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch = calib_done_i;
            end
            ST_BUS_WR, ST_BUS_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack wins over a timeout landing on the same cycle.
                if (wb_ack_i || bus_to) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!wb_ack_i) begin
                        err_d = 1'b1;
                    end
                    if (state_q == ST_BUS_WR) begin
                        wbuf_valid_d = 1'b0;
                    end else begin
                        ready_d = 1'b1;
                        rdata_d = wb_ack_i ? wb_dat_i : ERR_DATA;
                    end
                end
            end
            ST_RECOVER: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Last idle cycle may launch directly so the gap is exactly RECOVER_CYCLES.
                if (cnt_q == CNT_W'(RECOVER_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    launch  = calib_done_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (store_act && (!wbuf_valid_q || wr_done)) begin
            wbuf_valid_d = 1'b1;
            wbuf_adr_d   = cpu_adr_w;
            wbuf_dat_d   = cpu_wdata_i;
            wbuf_sel_d   = cpu_sel_i;
            ready_d      = 1'b1;
        end

        // Buffered write always goes first so a load never overtakes a store.
        if (launch && wbuf_valid_q) begin
            state_d = ST_BUS_WR;
            cnt_d   = '0;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = wbuf_adr_q;
            dat_d   = wbuf_dat_q;
            sel_d   = wbuf_sel_q;
        end else if (launch && load_act) begin
            state_d = ST_BUS_RD;
            cnt_d   = '0;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            adr_d   = cpu_adr_w;
            sel_d   = cpu_sel_i;
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = ready_q;
    assign err_o       = err_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_mem_master.sv
// Directed bench for wb_mem_master: calibration gating, posted writes, ordering,
// recovery gap, timeout and mid-cycle reset, with the slave driven by hand.
module tb_wb_mem_master;

    logic        clk;
    logic        rst;
    logic        calib;
    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        cyc;
    logic        stb;
    logic        wwe;
    logic [3:0]  wsel;
    logic [26:0] wadr;
    logic [31:0] wdat_o;
    logic [31:0] wdat_i;
    logic        ack;

    int checks = 0;
    int errors = 0;

    wb_mem_master dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .calib_done_i (calib),
        .cpu_req_i    (req),
        .cpu_we_i     (we),
        .cpu_sel_i    (sel),
        .cpu_addr_i   (addr),
        .cpu_wdata_i  (wdata),
        .cpu_rdata_o  (rdata),
        .cpu_ready_o  (ready),
        .err_o        (err),
        .wb_cyc_o     (cyc),
        .wb_stb_o     (stb),
        .wb_we_o      (wwe),
        .wb_sel_o     (wsel),
        .wb_adr_o     (wadr),
        .wb_dat_o     (wdat_o),
        .wb_dat_i     (wdat_i),
        .wb_ack_i     (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        ack = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu_issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        sel   = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; calib = 1'b0; req = 1'b0; we = 1'b0; sel = '0;
        addr = '0; wdata = '0; wdat_i = '0; ack = 1'b0;
        tick(); tick(); tick();
        checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL reset_cyc got cyc=%0b stb=%0b exp 0", cyc, stb); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", ready); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %08h exp 0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        checks++; if ({wwe, wsel, wadr, wdat_o} !== '0) begin errors++; $display("FAIL reset_bus got we=%0b sel=%h adr=%h dat=%h exp 0", wwe, wsel, wadr, wdat_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_calib_gate();
        int bad = 0;
        cpu_issue(1'b0, 32'h100, 32'h0, 4'hF);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cyc !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL calib_hold cyc high in %0d of 50 cycles exp 0", bad); end
        calib = 1'b1;
        tick();
        checks++; if (cyc !== 1'b1 || stb !== 1'b1) begin errors++; $display("FAIL calib_start got cyc=%0b stb=%0b exp 1", cyc, stb); end
        checks++; if (wadr !== 27'h100 || wwe !== 1'b0) begin errors++; $display("FAIL calib_adr got adr=%h we=%0b exp 100/0", wadr, wwe); end
        ack = 1'b1; wdat_i = 32'hCAFEF00D;
        tick();
        checks++; if (ready !== 1'b1 || rdata !== 32'hCAFEF00D || cyc !== 1'b0) begin errors++; $display("FAIL calib_read got ready=%0b rdata=%08h cyc=%0b exp 1/cafef00d/0", ready, rdata, cyc); end
        ack = 1'b0; req = 1'b0;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL calib_ready_pulse got %0b exp 0", ready); end
        idle(4);
    endtask

    task automatic test_posted_store();
        int bad = 0;
        cpu_issue(1'b1, 32'h40, 32'h12345678, 4'hF);
        tick();
        checks++; if (ready !== 1'b1 || cyc !== 1'b0) begin errors++; $display("FAIL store_ready got ready=%0b cyc=%0b exp 1/0", ready, cyc); end
        req = 1'b0;
        tick();
        checks++; if (cyc !== 1'b1 || wwe !== 1'b1 || wadr !== 27'h40 || wdat_o !== 32'h12345678 || wsel !== 4'hF) begin
            errors++; $display("FAIL store_bus got cyc=%0b we=%0b adr=%h dat=%h sel=%h exp 1/1/40/12345678/f", cyc, wwe, wadr, wdat_o, wsel);
        end
        for (int i = 0; i < 84; i++) begin
            tick();
            if (cyc !== 1'b1 || ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL store_wait bad cycles %0d exp 0", bad); end
        ack = 1'b1;
        tick();
        checks++; if (cyc !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL store_end got cyc=%0b err=%0b exp 0/0", cyc, err); end
        idle(4);
    endtask

    task automatic test_store_then_load();
        cpu_issue(1'b1, 32'h40, 32'h12345678, 4'hF);
        tick();
        req = 1'b0;
        tick();
        cpu_issue(1'b0, 32'h40, 32'h0, 4'hF);
        checks++; if (cyc !== 1'b1 || wwe !== 1'b1) begin errors++; $display("FAIL sl_write_first got cyc=%0b we=%0b exp 1/1", cyc, wwe); end
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (cyc !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL sl_gap1 got cyc=%0b ready=%0b exp 0/0", cyc, ready); end
        tick();
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL sl_gap2 got cyc=%0b exp 0", cyc); end
        tick();
        checks++; if (cyc !== 1'b1 || wwe !== 1'b0 || wadr !== 27'h40) begin errors++; $display("FAIL sl_read_start got cyc=%0b we=%0b adr=%h exp 1/0/40", cyc, wwe, wadr); end
        ack = 1'b1; wdat_i = 32'h12345678;
        tick();
        checks++; if (ready !== 1'b1 || rdata !== 32'h12345678) begin errors++; $display("FAIL sl_read_data got ready=%0b rdata=%08h exp 1/12345678", ready, rdata); end
        ack = 1'b0; req = 1'b0;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sl_single_pulse got %0b exp 0", ready); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        cpu_issue(1'b1, 32'h80, 32'h11111111, 4'h3);
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %0b exp 1", ready); end
        cpu_issue(1'b1, 32'h84, 32'h22222222, 4'hC);
        tick();
        checks++; if (cyc !== 1'b1 || wadr !== 27'h80 || wdat_o !== 32'h11111111 || wsel !== 4'h3) begin
            errors++; $display("FAIL b2b_first_bus got cyc=%0b adr=%h dat=%h sel=%h exp 1/80/11111111/3", cyc, wadr, wdat_o, wsel);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_blocked ready pulses %0d exp 0", bad); end
        ack = 1'b1;
        tick();
        checks++; if (ready !== 1'b1 || cyc !== 1'b0) begin errors++; $display("FAIL b2b_second_ready got ready=%0b cyc=%0b exp 1/0", ready, cyc); end
        ack = 1'b0; req = 1'b0;
        tick();
        tick();
        checks++; if (cyc !== 1'b1 || wadr !== 27'h84 || wdat_o !== 32'h22222222 || wsel !== 4'hC || ready !== 1'b0) begin
            errors++; $display("FAIL b2b_second_bus got cyc=%0b adr=%h dat=%h sel=%h ready=%0b exp 1/84/22222222/c/0", cyc, wadr, wdat_o, wsel, ready);
        end
        ack = 1'b1;
        tick();
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL b2b_end got cyc=%0b exp 0", cyc); end
        idle(4);
    endtask

    task automatic test_ack_on_timeout_cycle();
        cpu_issue(1'b0, 32'h180, 32'h0, 4'hF);
        tick();
        for (int i = 0; i < 1023; i++) tick();
        checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL edge_still_active got cyc=%0b exp 1", cyc); end
        ack = 1'b1; wdat_i = 32'h55AA55AA;
        tick();
        checks++; if (ready !== 1'b1 || rdata !== 32'h55AA55AA || err !== 1'b0) begin
            errors++; $display("FAIL edge_ack got ready=%0b rdata=%08h err=%0b exp 1/55aa55aa/0", ready, rdata, err);
        end
        idle(4);
    endtask

    task automatic test_timeout();
        int n = 0;
        cpu_issue(1'b0, 32'h200, 32'h0, 4'hF);
        tick();
        while (cyc === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        checks++; if (n != 1024) begin errors++; $display("FAIL to_length got %0d cycles exp 1024", n); end
        checks++; if (ready !== 1'b1 || rdata !== 32'hDEADBEEF || err !== 1'b1) begin
            errors++; $display("FAIL to_result got ready=%0b rdata=%08h err=%0b exp 1/deadbeef/1", ready, rdata, err);
        end
        idle(4);
        cpu_issue(1'b0, 32'h300, 32'h0, 4'hF);
        tick();
        checks++; if (cyc !== 1'b1 || wadr !== 27'h300) begin errors++; $display("FAIL to_next_start got cyc=%0b adr=%h exp 1/300", cyc, wadr); end
        ack = 1'b1; wdat_i = 32'h0BADF00D;
        tick();
        checks++; if (ready !== 1'b1 || rdata !== 32'h0BADF00D || err !== 1'b1) begin
            errors++; $display("FAIL to_next_read got ready=%0b rdata=%08h err=%0b exp 1/0badf00d/1", ready, rdata, err);
        end
        idle(4);
    endtask

    task automatic test_reset_mid_read();
        int bad = 0;
        cpu_issue(1'b0, 32'h400, 32'h0, 4'hF);
        tick();
        checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL rst_pre got cyc=%0b exp 1", cyc); end
        tick();
        rst = 1'b1; req = 1'b0;
        tick();
        checks++; if (cyc !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_mid got cyc=%0b ready=%0b rdata=%08h err=%0b exp 0/0/0/0", cyc, ready, rdata, err);
        end
        rst = 1'b0; ack = 1'b1; wdat_i = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cyc !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_stale_ack bad cycles %0d exp 0", bad); end
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_calib_gate();
        test_posted_store();
        test_store_then_load();
        test_back_to_back();
        test_ack_on_timeout_cycle();
        test_timeout();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
